// File: rtl/data_bus_sequencer_8bit.sv
// Upstream sequencer for the 8-bit 2-to-2 data bus: latches a request onto the bus, holds it, samples the return lanes.
// Optional drive/return self-check enabled by defining DATA_BUS_SEQ_SELFCHECK_EN (adds check_err port).
module data_bus_sequencer_8bit #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data1,
    input  logic [7:0]         in_data2,
    input  logic               in_swap,
    output logic [7:0]         bus_data1,
    output logic [7:0]         bus_data2,
    output logic               bus_select,
    input  logic [7:0]         bus_ret1,
    input  logic [7:0]         bus_ret2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data1,
    output logic [7:0]         out_data2,
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
    output logic               check_err,
`endif
    output logic               busy,
    output logic [COUNT_W-1:0] xfer_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

    logic [1:0]         state_q,      state_d;
    logic [7:0]         hold_cnt_q,   hold_cnt_d;
    logic [7:0]         bus_data1_q,  bus_data1_d;
    logic [7:0]         bus_data2_q,  bus_data2_d;
    logic               bus_select_q, bus_select_d;
    logic [7:0]         out_data1_q,  out_data1_d;
    logic [7:0]         out_data2_q,  out_data2_d;
    logic               out_valid_q,  out_valid_d;
    logic [COUNT_W-1:0] xfer_count_q, xfer_count_d;
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
    logic               check_err_q,  check_err_d;
    logic [7:0]         exp_ret1,     exp_ret2;
`endif

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        bus_data1_d  = bus_data1_q;
        bus_data2_d  = bus_data2_q;
        bus_select_d = bus_select_q;
        out_data1_d  = out_data1_q;
        out_data2_d  = out_data2_q;
        out_valid_d  = out_valid_q;
        xfer_count_d = xfer_count_q;
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
        check_err_d  = check_err_q;
        // The bus is a swap network, so the expected return is the latched drive, crossed when select is set.
        exp_ret1     = bus_select_q ? bus_data2_q : bus_data1_q;
        exp_ret2     = bus_select_q ? bus_data1_q : bus_data2_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bus_data1_d  = in_data1;
                    bus_data2_d  = in_data2;
                    bus_select_d = in_swap;
                    hold_cnt_d   = HOLD_M1;
                    state_d      = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_cnt_q != 8'd0) begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end else begin
                    out_data1_d = bus_ret1;
                    out_data2_d = bus_ret2;
                    out_valid_d = 1'b1;
                    state_d     = RESULT;
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
                    if ((bus_ret1 != exp_ret1) || (bus_ret2 != exp_ret2)) begin
                        check_err_d = 1'b1;
                    end
`endif
                end
            end
            RESULT: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    xfer_count_d = xfer_count_q + COUNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            bus_data1_q  <= '0;
            bus_data2_q  <= '0;
            bus_select_q <= 1'b0;
            out_data1_q  <= '0;
            out_data2_q  <= '0;
            out_valid_q  <= 1'b0;
            xfer_count_q <= '0;
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
            check_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            bus_data1_q  <= bus_data1_d;
            bus_data2_q  <= bus_data2_d;
            bus_select_q <= bus_select_d;
            out_data1_q  <= out_data1_d;
            out_data2_q  <= out_data2_d;
            out_valid_q  <= out_valid_d;
            xfer_count_q <= xfer_count_d;
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
            check_err_q  <= check_err_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign bus_data1  = bus_data1_q;
    assign bus_data2  = bus_data2_q;
    assign bus_select = bus_select_q;
    assign out_data1  = out_data1_q;
    assign out_data2  = out_data2_q;
    assign out_valid  = out_valid_q;
    assign xfer_count = xfer_count_q;
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
    assign check_err  = check_err_q;
`endif

endmodule

// File: tb/tb_data_bus_sequencer_8bit.sv
// Bench for data_bus_sequencer_8bit: swap-network bus model, transfer-level reference model, directed vectors.
module tb_data_bus_sequencer_8bit;

    localparam int HOLD = 2;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data1, in_data2;
    logic          in_swap;
    logic [7:0]    bus_data1, bus_data2;
    logic          bus_select;
    logic [7:0]    bus_ret1, bus_ret2;
    logic          out_valid, out_ready;
    logic [7:0]    out_data1, out_data2;
    logic          busy;
    logic [CW-1:0] xfer_count;
    logic          fault;
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
    logic          check_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    data_bus_sequencer_8bit #(.HOLD_CYCLES(HOLD), .COUNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data1   (in_data1),
        .in_data2   (in_data2),
        .in_swap    (in_swap),
        .bus_data1  (bus_data1),
        .bus_data2  (bus_data2),
        .bus_select (bus_select),
        .bus_ret1   (bus_ret1),
        .bus_ret2   (bus_ret2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
        .check_err  (check_err),
`endif
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Bus: 2-to-2 swap network; fault pins lane 1 to 8'hFF.
    assign bus_ret1 = fault ? 8'hFF : (bus_select ? bus_data2 : bus_data1);
    assign bus_ret2 = bus_select ? bus_data1 : bus_data2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Transfer-level model: a request in flight, its age in clocks, and a pending result.
    logic       m_fly, m_res, m_sel, m_err;
    int         m_age, m_count;
    logic [7:0] m_bus1, m_bus2, m_out1, m_out2;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fly <= 1'b0; m_res <= 1'b0; m_sel <= 1'b0; m_err <= 1'b0;
            m_age <= 0; m_count <= 0;
            m_bus1 <= '0; m_bus2 <= '0; m_out1 <= '0; m_out2 <= '0;
        end else if (m_res) begin
            if (out_ready) begin
                m_res   <= 1'b0;
                m_count <= (m_count + 1) % (1 << CW);
            end
        end else if (m_fly) begin
            if (m_age == HOLD - 1) begin
                m_fly  <= 1'b0;
                m_res  <= 1'b1;
                m_out1 <= fault ? 8'hFF : (m_sel ? m_bus2 : m_bus1);
                m_out2 <= m_sel ? m_bus1 : m_bus2;
                if (fault && ((m_sel ? m_bus2 : m_bus1) != 8'hFF)) m_err <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (in_valid) begin
            m_bus1 <= in_data1;
            m_bus2 <= in_data2;
            m_sel  <= in_swap;
            m_fly  <= 1'b1;
            m_age  <= 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready",   32'(in_ready),   32'(!(m_fly || m_res)));
            chk("busy",       32'(busy),       32'(m_fly || m_res));
            chk("out_valid",  32'(out_valid),  32'(m_res));
            chk("out_data1",  32'(out_data1),  32'(m_out1));
            chk("out_data2",  32'(out_data2),  32'(m_out2));
            chk("bus_data1",  32'(bus_data1),  32'(m_bus1));
            chk("bus_data2",  32'(bus_data2),  32'(m_bus2));
            chk("bus_select", 32'(bus_select), 32'(m_sel));
            chk("xfer_count", 32'(xfer_count), 32'(m_count));
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
            chk("check_err",  32'(check_err),  32'(m_err));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1 while idle; the request is taken at the next edge.
    task automatic drive_req(input logic [7:0] d1, input logic [7:0] d2, input logic sw);
        in_valid = 1'b1;
        in_data1 = d1;
        in_data2 = d2;
        in_swap  = sw;
        step(1);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data1 = '0; in_data2 = '0; in_swap = 1'b0;
        out_ready = 1'b1; fault = 1'b0;
        step(2);
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);

        // straight transfer
        drive_req(8'd1, 8'd2, 1'b0);
        chk("t1_bus1", 32'(bus_data1), 32'd1);
        chk("t1_bus2", 32'(bus_data2), 32'd2);
        chk("t1_sel", 32'(bus_select), 32'd0);
        step(1);
        chk("t1_early_valid", 32'(out_valid), 32'd0);
        step(1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_out1", 32'(out_data1), 32'd1);
        chk("t1_out2", 32'(out_data2), 32'd2);
        step(1);
        chk("t1_xfer", 32'(xfer_count), 32'd1);

        // swapped transfer
        drive_req(8'd2, 8'd1, 1'b1);
        step(2);
        chk("t2_out1", 32'(out_data1), 32'd1);
        chk("t2_out2", 32'(out_data2), 32'd2);
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
        chk("t2_check_err", 32'(check_err), 32'd0);
`endif
        step(1);
        chk("t2_xfer", 32'(xfer_count), 32'd2);

        // backpressure with a second request waiting
        out_ready = 1'b0;
        drive_req(8'd3, 8'd4, 1'b0);
        step(2);
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1; in_data1 = 8'd5; in_data2 = 8'd6; in_swap = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_out1", 32'(out_data1), 32'd3);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_bus1_frozen", 32'(bus_data1), 32'd3);
        end
        out_ready = 1'b1;
        step(1);
        chk("bp_xfer", 32'(xfer_count), 32'd3);
        chk("bp_not_taken", 32'(bus_data1), 32'd3);
        step(1);
        in_valid = 1'b0;
        chk("bp2_bus1", 32'(bus_data1), 32'd5);
        chk("bp2_sel", 32'(bus_select), 32'd1);
        step(2);
        chk("bp2_out1", 32'(out_data1), 32'd6);
        chk("bp2_out2", 32'(out_data2), 32'd5);
        step(1);
        chk("wrap_xfer", 32'(xfer_count), 32'd0);

        // reset one cycle after acceptance
        drive_req(8'd7, 8'd8, 1'b0);
        step(1);
        reset = 1'b1;
        #1;
        chk("rd_out_valid", 32'(out_valid), 32'd0);
        chk("rd_busy", 32'(busy), 32'd0);
        chk("rd_in_ready", 32'(in_ready), 32'd1);
        chk("rd_bus1", 32'(bus_data1), 32'd0);
        #2;
        reset = 1'b0;
        step(4);
        chk("rd_no_valid", 32'(out_valid), 32'd0);
        chk("rd_xfer", 32'(xfer_count), 32'd0);
        drive_req(8'd9, 8'd10, 1'b0);
        step(2);
        chk("rd2_out1", 32'(out_data1), 32'd9);
        step(1);
        chk("rd2_xfer", 32'(xfer_count), 32'd1);

        // lane-1 fault
        fault = 1'b1;
        drive_req(8'h11, 8'h22, 1'b0);
        step(2);
        chk("f_out1", 32'(out_data1), 32'hFF);
        chk("f_out2", 32'(out_data2), 32'h22);
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
        chk("f_check_err", 32'(check_err), 32'd1);
`endif
        step(1);
        fault = 1'b0;
        drive_req(8'h33, 8'h44, 1'b1);
        step(3);
        chk("f2_out1", 32'(out_data1), 32'h44);
        chk("f2_xfer", 32'(xfer_count), 32'd3);
`ifdef DATA_BUS_SEQ_SELFCHECK_EN
        chk("f2_sticky", 32'(check_err), 32'd1);
`endif
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_bus_sequencer_8bit.md
Name: data_bus_sequencer_8bit

Overview:
- Upstream stage for the 8-bit 2-to-2 data bus (two 8-bit lanes, select = lane swap).
- Accepts one transfer request per valid/ready handshake and registers both operands and the swap control onto the bus.
- Holds them stable for HOLD_CYCLES clocks, samples the two bus return lanes, and presents the sampled pair on an output valid/ready port.
- Counts completed transfers.

Parameters:
- HOLD_CYCLES, 2, clocks the bus drive is held before sampling the return lanes; legal range 1..255.
- COUNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data1  input  8  operand for bus lane 1.
- in_data2  input  8  operand for bus lane 2.
- in_swap  input  1  requested bus select value.
- bus_data1  output  8  registered drive to bus lane 1 input.
- bus_data2  output  8  registered drive to bus lane 2 input.
- bus_select  output  1  registered drive to bus select.
- bus_ret1  input  8  bus lane 1 output, returned.
- bus_ret2  input  8  bus lane 2 output, returned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data1  output  8  sampled bus_ret1.
- out_data2  output  8  sampled bus_ret2.
- busy  output  1  high in any state except IDLE.
- xfer_count  output  COUNT_W  completed transfers; wraps modulo 2^COUNT_W.

Behaviour:
- Clock and reset are decided: one clock; reset is asynchronous and active-high (ports clk, reset).
- Reset values: state IDLE; bus_data1, bus_data2, out_data1, out_data2 = 8'h00; bus_select, out_valid, busy = 0; xfer_count = 0; hold counter = 0.
- in_ready = 1 only in IDLE (combinational from state). Out of reset in_ready = 1.
- FSM states: IDLE, DRIVE, RESULT.
- IDLE:
  - On the edge with in_valid & in_ready: bus_data1 <= in_data1, bus_data2 <= in_data2, bus_select <= in_swap.
  - At the same edge: hold counter <= HOLD_CYCLES-1, then go to DRIVE.
  - in_valid low: stay in IDLE; bus outputs keep their last value.
- DRIVE:
  - Bus outputs are frozen.
  - Counter != 0: decrement.
  - Counter == 0: at that edge out_data1 <= bus_ret1, out_data2 <= bus_ret2, out_valid <= 1, go to RESULT.
- RESULT:
  - out_valid = 1 and out_data is stable until accepted.
  - On the edge with out_valid & out_ready: out_valid <= 0, xfer_count <= xfer_count+1, go to IDLE.
- Latency: acceptance edge E0 → out_valid high after edge E0+HOLD_CYCLES.
  - With out_ready tied high, the minimum request-to-request period is HOLD_CYCLES+2 clocks.
- No overlap: in_ready is low in DRIVE and RESULT, so requests there are held off. Upstream must keep in_valid and data stable until accepted.
- A new request cannot be accepted in the same cycle a result is accepted; it is taken in IDLE on the next cycle.
- Bus drive values persist after a transfer (not cleared) until the next acceptance.
- xfer_count wrap: 2^COUNT_W-1 → 0 on the next completion, no flag.
- Reset mid-operation (any state): immediate return to reset values. The in-flight transfer is dropped and not counted.
- HOLD_CYCLES = 1: the DRIVE counter starts at 0, and sampling occurs on the first edge after acceptance.

Optional Feature:
- Macro DATA_BUS_SEQ_SELFCHECK_EN.
- Defined:
  - Extra output port check_err (1 bit, reset 0).
  - At the sampling edge, the expected pair is computed from the latched drive:
    - select 0 → (bus_data1, bus_data2);
    - select 1 → (bus_data2, bus_data1).
  - check_err is sticky-set if bus_ret1/bus_ret2 differ from the expected pair. It is cleared only by reset.
- Undefined: no check_err port and no compare logic; all other behaviour is identical.

Test Plan:
- Reset then idle: assert reset mid-cycle → all outputs 0 immediately, in_ready=1, busy=0, xfer_count=0.
- Straight transfer, HOLD_CYCLES=2: in_data1=8'd1, in_data2=8'd2, in_swap=0, bus model = swap network → bus_data1=1, bus_data2=2, bus_select=0 one edge after acceptance. out_valid rises 2 edges after acceptance with out_data1=1, out_data2=2; xfer_count=1 after out_ready.
- Swapped transfer: in_data1=8'd2, in_data2=8'd1, in_swap=1 → out_data1=1, out_data2=2; with self-check enabled, check_err stays 0.
- Backpressure: out_ready=0 for 5 cycles → out_valid and out_data held, in_ready=0, second in_valid ignored. Release → second request accepted on the cycle after the result handshake.
- Reset during DRIVE: assert reset one cycle after acceptance → no out_valid, xfer_count remains 0. The next request completes normally.
- Fault and wrap (COUNT_W=2): bus model forces bus_ret1=8'hFF → check_err=1 and sticky when enabled. Complete 4 transfers → xfer_count returns to 0.
